quad_decoder: RTL

Quadrature decoder that turns a two-phase incremental encoder (A/B) into the signals the 4-bit up/down counter consumes. It synchronizes the raw phases, decodes every valid Gray-code transition (4x decoding), and emits a direction bit, a single-cycle step strobe and its own wrapping position count. It sits between the off-chip encoder pins and the up/down counting logic.

---
 rtl/quad_decoder_pkg.sv | 17 +
 rtl/quad_decoder_sync.sv | 21 ++
 rtl/quad_decoder.sv | 64 ++++++
 3 files changed

// File: rtl/quad_decoder_pkg.sv
// quad_pkg: phase-state constants, up-order successor and priming FSM encodings
package quad_pkg;

    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_10 = 2'b10;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_01 = 2'b01;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} prime_t;

    function automatic logic [1:0] up_next(input logic [1:0] s);
        return s == QS_00 ? QS_10 :
               s == QS_10 ? QS_11 :
               s == QS_11 ? QS_01 : QS_00;
    endfunction

endpackage

// File: rtl/quad_decoder_sync.sv
// bit_sync: N-stage single-bit synchronizer, synchronous reset to 0
module bit_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic synced
);

    logic [N-1:0] stages;

    // shift the raw level through the flop chain
    always_ff @(posedge clk) begin
        if (reset) stages <= '0;
        else       stages <= {stages[N-2:0], raw};
    end

    assign synced = stages[N-1];

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: 4x quadrature decoder producing direction, step/err pulses and a wrapping position
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             up_down,
    output logic             step,
    output logic             err
);

    logic       a_s, b_s;
    logic [1:0] cur, prev, fill;
    logic       is_up, is_dn, is_bad;
    prime_t     fsm;

    bit_sync #(.N(SYNC_STAGES)) sync_a (.clk(clk), .reset(reset), .raw(enc_a), .synced(a_s));
    bit_sync #(.N(SYNC_STAGES)) sync_b (.clk(clk), .reset(reset), .raw(enc_b), .synced(b_s));

    assign cur    = {a_s, b_s};
    assign is_up  = cur == up_next(prev);
    assign is_dn  = prev == up_next(cur);
    assign is_bad = (cur ^ prev) == 2'b11;

    // prime prev once the reset zeros have drained from the synchronizers, then classify each sample
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm     <= IDLE;
            fill    <= '0;
            prev    <= QS_00;
            count   <= '0;
            up_down <= 1'b1;
            step    <= 1'b0;
            err     <= 1'b0;
        end else begin
            prev <= cur;
            step <= 1'b0;
            err  <= 1'b0;
            if (fsm == IDLE) begin
                fill <= fill + 1'b1;
                if (fill == 2'(SYNC_STAGES)) fsm <= RUN;
            end else if (is_up) begin
                count   <= count + 1'b1;
                up_down <= 1'b1;
                step    <= 1'b1;
            end else if (is_dn) begin
                count   <= count - 1'b1;
                up_down <= 1'b0;
                step    <= 1'b1;
            end else if (is_bad) begin
                err <= 1'b1;
            end
            if (clear) count <= '0;
        end
    end

endmodule
